// File: rtl/multicycle_ctrl.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | multicycle_ctrl : multi-cycle RV32I subset (addi/add/bne/ecall) sequencer |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
module multicycle_ctrl #(
  parameter int                  DATA_WIDTH = 32,
  parameter int                  ADD_WIDTH  = 5,
  parameter int                  PC_WIDTH   = 32,
  parameter logic [PC_WIDTH-1:0] RESET_PC   = '0
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  output logic [PC_WIDTH-1:0]   instr_addr,
  input  logic [31:0]           instr,
  input  logic                  EQ,
  output logic [ADD_WIDTH-1:0]  AD1,
  output logic [ADD_WIDTH-1:0]  AD2,
  output logic [ADD_WIDTH-1:0]  AD3,
  output logic                  WE3,
  output logic                  ALUsrc,
  output logic [DATA_WIDTH-1:0] Immop,
  output logic                  busy,
  output logic                  halted,
  output logic                  illegal
);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_FETCH  = 3'd1;
  localparam logic [2:0] S_DECODE = 3'd2;
  localparam logic [2:0] S_EXEC   = 3'd3;
  localparam logic [2:0] S_WB     = 3'd4;
  localparam logic [2:0] S_HALT   = 3'd5;

  logic [2:0]          state_q, state_d;
  logic [PC_WIDTH-1:0] pc_q, pc_d;
  logic [31:0]         ir_q, ir_d;
  logic                illegal_q, illegal_d;

  logic [6:0]          opcode;
  logic [2:0]          funct3;
  logic                is_addi, is_add, is_bne, is_ecall;
  logic [PC_WIDTH-1:0] br_off, br_target;

  assign opcode   = ir_q[6:0];
  assign funct3   = ir_q[14:12];
  assign is_addi  = (opcode == 7'b0010011) && (funct3 == 3'b000);
  assign is_add   = (opcode == 7'b0110011) && (funct3 == 3'b000) && (ir_q[31:25] == 7'd0);
  assign is_bne   = (opcode == 7'b1100011) && (funct3 == 3'b001);
  assign is_ecall = (ir_q == 32'h0000_0073);

  // B-type offset is sign-extended to the full PC width so wrap-around stays modular
  assign br_off    = {{(PC_WIDTH-13){ir_q[31]}}, ir_q[31], ir_q[7], ir_q[30:25], ir_q[11:8], 1'b0};
  assign br_target = EQ ? (pc_q + PC_WIDTH'(4)) : (pc_q + br_off);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      pc_q      <= RESET_PC;
      ir_q      <= '0;
      illegal_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      pc_q      <= pc_d;
      ir_q      <= ir_d;
      illegal_q <= illegal_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    pc_d      = pc_q;
    ir_d      = ir_q;
    illegal_d = illegal_q;
    case (state_q)
      S_IDLE, S_HALT: begin
        if (start) begin
          state_d   = S_FETCH;
          pc_d      = RESET_PC;
          illegal_d = 1'b0;
        end
      end
      S_FETCH:  state_d = S_DECODE;
      S_DECODE: begin
        ir_d    = instr;
        state_d = S_EXEC;
      end
      S_EXEC: begin
        if (is_addi || is_add) begin
          state_d = S_WB;
        end else if (is_bne) begin
          if (br_target[1]) begin
            state_d   = S_HALT;
            illegal_d = 1'b1;
          end else begin
            pc_d    = br_target;
            state_d = S_FETCH;
          end
        end else begin
          state_d   = S_HALT;
          illegal_d = !is_ecall;
        end
      end
      S_WB: begin
        pc_d    = pc_q + PC_WIDTH'(4);
        state_d = S_FETCH;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    AD1    = '0;
    AD2    = '0;
    AD3    = '0;
    WE3    = 1'b0;
    ALUsrc = 1'b0;
    Immop  = '0;
    if (state_q == S_EXEC || state_q == S_WB) begin
      AD1    = ADD_WIDTH'(ir_q[19:15]);
      AD2    = ADD_WIDTH'(ir_q[24:20]);
      AD3    = ADD_WIDTH'(ir_q[11:7]);
      ALUsrc = is_addi;
      if (is_addi) Immop = {{(DATA_WIDTH-12){ir_q[31]}}, ir_q[31:20]};
      // x0 is hard-wired, so a write to it is suppressed rather than issued
      WE3    = (state_q == S_WB) && (ir_q[11:7] != 5'd0);
    end
  end

  assign instr_addr = pc_q;
  assign busy       = (state_q == S_FETCH) || (state_q == S_DECODE) ||
                      (state_q == S_EXEC)  || (state_q == S_WB);
  assign halted     = (state_q == S_HALT);
  assign illegal    = illegal_q;

endmodule
`default_nettype wire

// File: tb/tb_multicycle_ctrl.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_multicycle_ctrl : instruction-level reference model bench             |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
module tb_multicycle_ctrl;

  localparam logic [31:0] RESET_PC = 32'd0;
  localparam int K_ADDI = 0, K_ADD = 1, K_BNE = 2, K_ECALL = 3, K_ILL = 4;

  logic        clk, rst_n, start, EQ;
  logic [31:0] instr_addr, instr, Immop;
  logic [4:0]  AD1, AD2, AD3;
  logic        WE3, ALUsrc, busy, halted, illegal;

  logic [31:0] mem [0:63];
  logic [31:0] m_pc;
  bit          m_halt, m_ill;
  int          n_cmp, n_err;

  multicycle_ctrl #(
    .DATA_WIDTH(32), .ADD_WIDTH(5), .PC_WIDTH(32), .RESET_PC(RESET_PC)
  ) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .instr_addr(instr_addr),
    .instr(instr), .EQ(EQ), .AD1(AD1), .AD2(AD2), .AD3(AD3), .WE3(WE3),
    .ALUsrc(ALUsrc), .Immop(Immop), .busy(busy), .halted(halted), .illegal(illegal)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // synchronous-read instruction memory (256 bytes, address wraps)
  always @(posedge clk) instr <= mem[instr_addr[7:2]];

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h (pc %h, t=%0t)", tag, got, exp, m_pc, $time);
    end
  endtask

  function automatic int kind(input logic [31:0] w);
    if (w == 32'h0000_0073) return K_ECALL;
    if (w[6:0] == 7'h13 && w[14:12] == 3'd0) return K_ADDI;
    if (w[6:0] == 7'h33 && w[14:12] == 3'd0 && w[31:25] == 7'd0) return K_ADD;
    if (w[6:0] == 7'h63 && w[14:12] == 3'd1) return K_BNE;
    return K_ILL;
  endfunction

  function automatic logic [31:0] sext12(input logic [31:0] w);
    int v;
    v = int'(w[31:20]);
    if (v >= 2048) v -= 4096;
    return 32'(v);
  endfunction

  function automatic logic [31:0] boff(input logic [31:0] w);
    int v;
    v = int'({w[31], w[7], w[30:25], w[11:8], 1'b0});
    if (v >= 4096) v -= 8192;
    return 32'(v);
  endfunction

  function automatic logic [31:0] enc_addi(input logic [4:0] rd, input logic [4:0] rs1, input int imm);
    logic [11:0] i12;
    i12 = 12'(imm);
    return {i12, rs1, 3'b000, rd, 7'h13};
  endfunction

  function automatic logic [31:0] enc_add(input logic [4:0] rd, input logic [4:0] rs1, input logic [4:0] rs2);
    return {7'h00, rs2, rs1, 3'b000, rd, 7'h33};
  endfunction

  function automatic logic [31:0] enc_bne(input logic [4:0] rs1, input logic [4:0] rs2, input int off);
    logic [12:0] b;
    b = 13'(off);
    return {b[12], b[10:5], rs2, rs1, 3'b001, b[4:1], b[11], 7'h63};
  endfunction

  task automatic chk_quiet(input string tag);
    chk({tag, "_fields"}, 32'({AD1, AD2, AD3, WE3, ALUsrc}), 32'd0);
    chk({tag, "_imm"}, Immop, 32'd0);
  endtask

  // Called at a negedge while the DUT sits in IDLE or HALT
  task automatic start_run();
    start = 1'b1;
    @(negedge clk);
    start  = 1'b0;
    m_pc   = RESET_PC;
    m_ill  = 1'b0;
    m_halt = 1'b0;
    chk("start_addr", instr_addr, RESET_PC);
    chk("start_busy", 32'(busy), 32'd1);
    chk("start_illegal", 32'(illegal), 32'd0);
    chk("start_halted", 32'(halted), 32'd0);
  endtask

  // Called at the negedge of a FETCH cycle; executes one instruction against the model
  task automatic run_instr(input bit eq_v);
    logic [31:0] w, tgt;
    int k;
    w = mem[m_pc[7:2]];
    k = kind(w);
    for (int c = 0; c < 2; c++) begin
      chk("fd_busy", 32'(busy), 32'd1);
      chk("fd_addr", instr_addr, m_pc);
      chk_quiet("fd");
      start = 1'($urandom_range(0, 1));
      @(negedge clk);
    end
    chk("ex_addr", instr_addr, m_pc);
    chk("ex_busy", 32'(busy), 32'd1);
    chk("ex_we", 32'(WE3), 32'd0);
    if (k == K_ADDI || k == K_ADD || k == K_BNE) begin
      chk("ex_ad1", 32'(AD1), 32'(w[19:15]));
      chk("ex_ad2", 32'(AD2), 32'(w[24:20]));
      chk("ex_ad3", 32'(AD3), 32'(w[11:7]));
      chk("ex_src", 32'(ALUsrc), (k == K_ADDI) ? 32'd1 : 32'd0);
      if (k != K_ADD) chk("ex_imm", Immop, (k == K_ADDI) ? sext12(w) : 32'd0);
    end
    EQ    = eq_v;
    start = 1'($urandom_range(0, 1));
    @(negedge clk);
    start = 1'b0;
    EQ    = 1'($urandom_range(0, 1));
    if (k == K_ADDI || k == K_ADD) begin
      chk("wb_addr", instr_addr, m_pc);
      chk("wb_busy", 32'(busy), 32'd1);
      chk("wb_we", 32'(WE3), (w[11:7] != 5'd0) ? 32'd1 : 32'd0);
      chk("wb_ad1", 32'(AD1), 32'(w[19:15]));
      chk("wb_ad3", 32'(AD3), 32'(w[11:7]));
      chk("wb_src", 32'(ALUsrc), (k == K_ADDI) ? 32'd1 : 32'd0);
      if (k == K_ADDI) chk("wb_imm", Immop, sext12(w));
      start = 1'($urandom_range(0, 1));
      @(negedge clk);
      start = 1'b0;
      m_pc  = m_pc + 32'd4;
    end else if (k == K_BNE) begin
      tgt = eq_v ? m_pc + 32'd4 : m_pc + boff(w);
      if ((tgt % 4) == 2) begin
        m_halt = 1'b1;
        m_ill  = 1'b1;
      end else begin
        m_pc = tgt;
      end
    end else begin
      m_halt = 1'b1;
      m_ill  = (k == K_ILL);
    end
    chk("post_addr", instr_addr, m_pc);
    chk("post_halted", 32'(halted), 32'(m_halt));
    chk("post_busy", 32'(busy), 32'(!m_halt));
    chk("post_illegal", 32'(illegal), 32'(m_ill));
    chk_quiet("post");
  endtask

  task automatic reset_pulse(input string tag);
    rst_n = 1'b0;
    #1;
    chk({tag, "_addr"}, instr_addr, RESET_PC);
    chk({tag, "_busy"}, 32'(busy), 32'd0);
    chk({tag, "_halted"}, 32'(halted), 32'd0);
    chk({tag, "_illegal"}, 32'(illegal), 32'd0);
    chk_quiet(tag);
    @(negedge clk);
    rst_n = 1'b1;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      chk({tag, "_idle_busy"}, 32'(busy), 32'd0);
      chk({tag, "_idle_addr"}, instr_addr, RESET_PC);
    end
  endtask

  initial begin
    n_cmp = 0;
    n_err = 0;
    m_pc  = RESET_PC;
    rst_n = 1'b1;
    start = 1'b0;
    EQ    = 1'b0;
    for (int i = 0; i < 64; i++) mem[i] = 32'h0000_0073;
    #3 rst_n = 1'b0;
    @(negedge clk);
    chk_quiet("rst");
    chk("rst_addr", instr_addr, RESET_PC);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_halted", 32'(halted), 32'd0);
    chk("rst_illegal", 32'(illegal), 32'd0);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    chk("idle_busy", 32'(busy), 32'd0);

    // addi/addi/bne loop taken once (EQ=0) then fall-through (EQ=1), x0 write, ecall
    mem[0] = 32'h0050_0093;
    mem[1] = 32'hFFF0_0113;
    mem[2] = 32'hFE20_9CE3;
    mem[3] = 32'h0010_0013;
    mem[4] = 32'h0000_0073;
    start_run();
    for (int i = 0; i < 8; i++) run_instr(i == 5);
    chk("dirA_halted", 32'(halted), 32'd1);
    chk("dirA_pc", instr_addr, 32'd16);

    // illegal word at PC=4, then restart clears the fault
    mem[1] = 32'hFFFF_FFFF;
    start_run();
    run_instr(1'b0);
    run_instr(1'b0);
    chk("dirB_illegal", 32'(illegal), 32'd1);
    chk("dirB_pc", instr_addr, 32'd4);
    start_run();

    // reset pulled during WB of an addi
    run_instr(1'b0);
    reset_pulse("midrun");
    start_run();
    repeat (3) @(negedge clk);
    chk("wbrst_we_before", 32'(WE3), 32'd1);
    reset_pulse("wbrst");

    // randomized programs
    for (int p = 0; p < 8; p++) begin
      for (int i = 0; i < 64; i++) begin
        int r, t;
        r = $urandom_range(0, 99);
        if (r < 35)      mem[i] = enc_addi(5'($urandom), 5'($urandom), int'($urandom_range(0, 4095)) - 2048);
        else if (r < 60) mem[i] = enc_add(5'($urandom), 5'($urandom), 5'($urandom));
        else if (r < 85) begin
          t = $urandom_range(0, 16);
          mem[i] = enc_bne(5'($urandom), 5'($urandom), 4 * (t - 8) + (($urandom_range(0, 4) == 0) ? 2 : 0));
        end
        else if (r < 88) mem[i] = 32'h0000_0073;
        else             mem[i] = $urandom;
      end
      start_run();
      for (int n = 0; n < 30 && !m_halt; n++) run_instr(1'($urandom_range(0, 1)));
      if (!m_halt) reset_pulse("rand_rst");
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/multicycle_ctrl.md
# multicycle_ctrl

Multi-cycle control unit that sequences the register-file/ALU datapath. It fetches RV32I instruction words from a synchronous-read instruction memory, decodes a subset (addi, add, bne, ecall), and drives the datapath's register addresses, write enable, operand select and immediate. It closes the branch loop using the datapath's EQ flag. It sits between instruction memory and the datapath in the top level and owns the program counter.

## Interface
- DATA_WIDTH, 32, datapath/immediate width
- ADD_WIDTH, 5, register address width
- PC_WIDTH, 32, program counter width
- RESET_PC, 0, PC loaded on reset and on start

- clk  input  1  system clock, all state updates on rising edge
- rst_n  input  1  reset, asynchronous, active-low
- start  input  1  begin execution from RESET_PC (honoured in IDLE and HALT only)
- instr_addr  output  PC_WIDTH  instruction memory address (= PC register)
- instr  input  32  instruction word, valid one cycle after instr_addr is presented
- EQ  input  1  datapath ALU equality flag (RD1 == ALU operand 2)
- AD1, AD2, AD3  output  ADD_WIDTH  rs1, rs2, rd to register file
- WE3  output  1  register file write enable
- ALUsrc  output  1  1 = Immop as ALU operand 2, 0 = RD2
- Immop  output  DATA_WIDTH  sign-extended immediate
- busy  output  1  high in FETCH/DECODE/EXEC/WB
- halted  output  1  high in HALT
- illegal  output  1  sticky; set when HALT is entered on a fault, cleared by start or reset

## Operation
- States: IDLE, FETCH, DECODE, EXEC, WB, HALT. Reset → IDLE, PC=RESET_PC, IR=0.
- IDLE/HALT + start=1 → FETCH, PC=RESET_PC, illegal cleared.
- FETCH → DECODE unconditionally. At the end of DECODE, IR is loaded from instr.
- Decode from IR:
  - addi: opcode 0010011, funct3 000. ALUsrc=1, Immop=sext(IR[31:20]).
  - add: opcode 0110011, funct3 000, funct7 0. ALUsrc=0.
  - bne: opcode 1100011, funct3 001. ALUsrc=0, Immop=0.
  - ecall: exactly 0x00000073.
  - Anything else is illegal.
- EXEC:
  - addi/add → WB.
  - bne: EQ sampled at the end of EXEC.
    - EQ=0: target = PC + sext({IR[31],IR[7],IR[30:25],IR[11:8],0}).
    - EQ=1: target = PC + 4.
    - If target[1]=1 → HALT with illegal=1, PC unchanged. Otherwise PC=target and → FETCH.
  - ecall → HALT, illegal=0, PC unchanged.
  - illegal → HALT, illegal=1, PC unchanged.
- WB: WE3=1 for one cycle, unless rd=0, in which case WE3 stays 0. PC=PC+4, → FETCH.
- Output rules:
  - AD1=IR[19:15], AD2=IR[24:20], AD3=IR[11:7], ALUsrc and Immop are decoded from IR. They are held stable through EXEC and WB.
  - These outputs are forced to 0 in IDLE, FETCH, DECODE and HALT.
  - WE3 is high only in WB and is never high in any other state.
- PC arithmetic is modulo 2^PC_WIDTH; wrap-around is silent.
- start outside IDLE/HALT is ignored.

## Timing
- Reset values: instr_addr=RESET_PC; AD1=AD2=AD3=0; WE3=0; ALUsrc=0; Immop=0; busy=0; halted=0; illegal=0.
- Latency from start to the first instr_addr: RESET_PC is on instr_addr in the cycle after start.
- Cycles per instruction:
  - addi/add: 4 (FETCH, DECODE, EXEC, WB).
  - bne: 3.
  - ecall/illegal: 3, then HALT.
- instr_addr changes only on the FETCH entry edge (the edge leaving WB or EXEC). It is constant from FETCH through the end of that instruction.
- The register-file write occurs on the clk edge that ends WB.
- rst_n assertion mid-instruction (including during WB): all outputs return to reset values asynchronously, and no write is completed. Release: IDLE on the first edge after rst_n rises.
- The start/rst_n interaction is defined: rst_n dominates.

## Test plan
- Reset, start, instr[0]=0x00500093 (addi x1,x0,5) → in WB cycle (4th after FETCH): WE3=1, AD1=0, AD3=1, ALUsrc=1, Immop=5. Next instr_addr=4.
- addi x2,x0,-1 (0xFFF00113) → Immop=0xFFFFFFFF, AD3=2. addi x0,x0,1 (0x00100013) → WE3 never asserted, PC advances by 4.
- bne x1,x2,-8 at PC=8:
  - EQ=0 in EXEC → next instr_addr=0, 3-cycle instruction, WE3 stays 0.
  - Repeat with EQ=1 → next instr_addr=12.
- instr=0xFFFFFFFF at PC=4 → halted=1, illegal=1, instr_addr stays 4, WE3 never high. Then start → instr_addr=RESET_PC, illegal=0.
- ecall (0x00000073) → halted=1, illegal=0, busy=0. start pulses in FETCH/EXEC are ignored, checked by the PC sequence being unchanged.
- rst_n pulled low during WB of an addi → WE3=0 before the next edge, busy=0, instr_addr=RESET_PC. After release, the controller stays in IDLE until start.
